// File: rtl/zap_thumb_halfword_splitter_pkg.sv
// Shared constants for the fetch-to-decode halfword splitter:
// FSM encodings and the CPSR Thumb flag position.
package zap_thumb_halfword_splitter_pkg;
  localparam int CPSR_T_BIT = 5;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  function automatic logic [31:0] zext_hw(input logic [15:0] hw);
    return {16'd0, hw};
  endfunction
endpackage

// File: rtl/zap_thumb_halfword_splitter_if.sv
// Fetch-in / decode-out bundle for the halfword splitter.
interface zap_thumb_halfword_splitter_if #(parameter int ADDR_W = 32);
  logic [31:0]       i_instruction;
  logic              i_instruction_valid;
  logic [ADDR_W-1:0] i_pc;
  logic [31:0]       i_cpsr_ff;
  logic              i_irq;
  logic              i_fiq;
  logic              i_stall;
  logic              i_clear;
  logic [31:0]       o_instruction;
  logic              o_instruction_valid;
  logic [ADDR_W-1:0] o_pc;
  logic              o_irq;
  logic              o_fiq;
  logic              o_stall;

  modport slave (
    input  i_instruction, i_instruction_valid, i_pc, i_cpsr_ff,
           i_irq, i_fiq, i_stall, i_clear,
    output o_instruction, o_instruction_valid, o_pc, o_irq, o_fiq, o_stall
  );

  modport master (
    output i_instruction, i_instruction_valid, i_pc, i_cpsr_ff,
           i_irq, i_fiq, i_stall, i_clear,
    input  o_instruction, o_instruction_valid, o_pc, o_irq, o_fiq, o_stall
  );
endinterface

// File: rtl/zap_thumb_halfword_splitter.sv
// Registers ARM words straight through; in Thumb state emits each fetched
// word as one or two zero-extended halfwords with their own PCs.
module zap_thumb_halfword_splitter
  import zap_thumb_halfword_splitter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int T_BIT  = CPSR_T_BIT
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  zap_thumb_halfword_splitter_if.slave     bus
);
  logic [0:0]        state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              irq_q, irq_d;
  logic              fiq_q, fiq_d;
  logic [15:0]       buf_hi_q, buf_hi_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic              adv, acc, thumb;

  assign adv   = !bus.i_stall || !vld_q;
  assign acc   = (state_q == ST_IDLE) && adv;
  assign thumb = bus.i_cpsr_ff[T_BIT];

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    vld_d    = vld_q;
    pc_d     = pc_q;
    irq_d    = irq_q;
    fiq_d    = fiq_q;
    buf_hi_d = buf_hi_q;
    buf_pc_d = buf_pc_q;
    if (bus.i_clear) begin
      // Flush beats everything: drop the pending halfword and the incoming word.
      state_d = ST_IDLE;
      vld_d   = 1'b0;
      irq_d   = 1'b0;
      fiq_d   = 1'b0;
    end else if (adv) begin
      if (state_q == ST_SECOND) begin
        // Interrupts ride only on the first item of a word.
        instr_d = zext_hw(buf_hi_q);
        pc_d    = buf_pc_q;
        irq_d   = 1'b0;
        fiq_d   = 1'b0;
        vld_d   = 1'b1;
        state_d = ST_IDLE;
      end else if (bus.i_instruction_valid) begin
        vld_d = 1'b1;
        pc_d  = bus.i_pc;
        irq_d = bus.i_irq;
        fiq_d = bus.i_fiq;
        if (!thumb) begin
          instr_d = bus.i_instruction;
        end else if (!bus.i_pc[1]) begin
          instr_d  = zext_hw(bus.i_instruction[15:0]);
          buf_hi_d = bus.i_instruction[31:16];
          buf_pc_d = bus.i_pc + ADDR_W'(2);
          state_d  = ST_SECOND;
        end else begin
          instr_d = zext_hw(bus.i_instruction[31:16]);
        end
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      vld_q    <= 1'b0;
      pc_q     <= '0;
      irq_q    <= 1'b0;
      fiq_q    <= 1'b0;
      buf_hi_q <= '0;
      buf_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
      pc_q     <= pc_d;
      irq_q    <= irq_d;
      fiq_q    <= fiq_d;
      buf_hi_q <= buf_hi_d;
      buf_pc_q <= buf_pc_d;
    end
  end

  assign bus.o_instruction       = instr_q;
  assign bus.o_instruction_valid = vld_q;
  assign bus.o_pc                = pc_q;
  assign bus.o_irq               = irq_q;
  assign bus.o_fiq               = fiq_q;
  assign bus.o_stall             = !acc;

  logic unused_ok;
  assign unused_ok = ^{bus.i_cpsr_ff, bus.i_pc[0]};
endmodule
